// File: rtl/framebuffer_controller.sv
// Double-buffered pixel store: the front bank feeds display_driver, the host writes or clears the back bank.
// Banks swap only on frame_complete. Optional `FB_CLEAR_COLOR_EN adds a clear_color input (otherwise clears to 0).
module framebuffer_controller #(
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitwidth = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(rows)-1:0]      disp_row,
  input  logic [$clog2(columns)-1:0]   disp_column,
  output logic [3*bitwidth-1:0]        disp_pixel,
  input  logic                         frame_complete,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(rows)-1:0]      wr_row,
  input  logic [$clog2(columns)-1:0]   wr_column,
  input  logic [3*bitwidth-1:0]        wr_data,
  input  logic                         swap_req,
  output logic                         swap_ack,
  output logic                         front_bank,
  input  logic                         clear_req,
`ifdef FB_CLEAR_COLOR_EN
  input  logic [3*bitwidth-1:0]        clear_color,
`endif
  output logic                         clear_busy
);

  localparam int RW    = $clog2(rows);
  localparam int CW    = $clog2(columns);
  localparam int AW    = 1 + RW + CW;
  localparam int PIX_W = 3 * bitwidth;

  typedef enum logic [1:0] {IDLE, SWAP_WAIT, CLEAR} state_t;

  state_t               state;
  logic [RW+CW-1:0]     counter;
  logic                 pending;
  logic                 clear_accept;
  logic [PIX_W-1:0]     clear_value;

  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [PIX_W-1:0]     mem_wdata;
  logic [PIX_W-1:0]     mem [2**AW];

  assign clear_accept = (state == IDLE) && !swap_req && clear_req;

`ifdef FB_CLEAR_COLOR_EN
  // Colour is captured once so a changing input cannot produce a striped clear.
  always_ff @(posedge clk) begin
    if (clear_accept) clear_value <= clear_color;
  end
`else
  assign clear_value = '0;
`endif

  // Control FSM; all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      front_bank <= 1'b0;
      swap_ack   <= 1'b0;
      clear_busy <= 1'b0;
      wr_ready   <= 1'b0;
      counter    <= '0;
      pending    <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state)
        IDLE: begin
          wr_ready <= 1'b1;
          // An ack still high this cycle defers the swap to keep acks from merging.
          if (swap_req && frame_complete && !swap_ack) begin
            front_bank <= ~front_bank;
            swap_ack   <= 1'b1;
          end else if (swap_req) begin
            state    <= SWAP_WAIT;
            wr_ready <= 1'b0;
          end else if (clear_req) begin
            state      <= CLEAR;
            wr_ready   <= 1'b0;
            clear_busy <= 1'b1;
            counter    <= '0;
          end
        end
        SWAP_WAIT: begin
          if (frame_complete) begin
            front_bank <= ~front_bank;
            swap_ack   <= 1'b1;
            state      <= IDLE;
            wr_ready   <= 1'b1;
          end
        end
        CLEAR: begin
          counter <= counter + 1'b1;
          if (swap_req) pending <= 1'b1;
          if (counter == '1) begin
            clear_busy <= 1'b0;
            pending    <= 1'b0;
            if (pending || swap_req) begin
              state <= SWAP_WAIT;
            end else begin
              state    <= IDLE;
              wr_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single back-bank write port shared by host writes and the clear sweep.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {~front_bank, wr_row, wr_column};
    mem_wdata = wr_data;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = {~front_bank, counter};
      mem_wdata = clear_value;
    end else if (state == IDLE && wr_valid && wr_ready) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Display read stage: one registered cycle, never stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) disp_pixel <= '0;
    else      disp_pixel <= mem[{front_bank, disp_row, disp_column}];
  end

endmodule

// File: tb/tb_framebuffer_controller.sv
// Randomized plus directed bench for framebuffer_controller against a behavioural bank/mode model.
module tb_framebuffer_controller;
  localparam int ROWS = 8, COLS = 32, BW = 8, PW = 3 * BW, N = ROWS * COLS;

  logic          clk = 1'b0, rst = 1'b0;
  logic [2:0]    disp_row = '0, wr_row = '0;
  logic [4:0]    disp_column = '0, wr_column = '0;
  logic [PW-1:0] disp_pixel, wr_data = '0, clear_color = 24'h00ff00;
  logic          frame_complete = 0, wr_valid = 0, swap_req = 0, clear_req = 0;
  logic          wr_ready, swap_ack, front_bank, clear_busy;

  always #5 clk = ~clk;

  framebuffer_controller #(.rows(ROWS), .columns(COLS), .bitwidth(BW)) dut (
    .clk(clk), .rst(rst),
    .disp_row(disp_row), .disp_column(disp_column), .disp_pixel(disp_pixel),
    .frame_complete(frame_complete),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_column(wr_column), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_bank(front_bank),
    .clear_req(clear_req),
`ifdef FB_CLEAR_COLOR_EN
    .clear_color(clear_color),
`endif
    .clear_busy(clear_busy)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: two banks as a flat array, plus mode 0=idle 1=awaiting frame 2=clearing.
  logic [PW-1:0] mm [2*N];
  bit            known [2*N];
  int            mode = 0, m_cidx = 0;
  bit            m_front, m_ack, m_ready, m_pend, m_pix_known, prev_ack;
  logic [PW-1:0] m_cval, m_pix;

  function automatic logic [PW-1:0] clear_val();
`ifdef FB_CLEAR_COLOR_EN
    return clear_color;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    mode = 0; m_front = 0; m_ack = 0; m_ready = 0; m_pend = 0;
    m_pix = '0; m_pix_known = 1; prev_ack = 0;
  endtask

  task automatic model_edge();
    int ra, back, a;
    bit ack_n;
    ra = (m_front ? N : 0) + int'(disp_row) * COLS + int'(disp_column);
    m_pix_known = known[ra];
    m_pix = mm[ra];
    back = m_front ? 0 : N;
    ack_n = 0;
    case (mode)
      0: begin
        if (wr_valid && m_ready) begin
          a = back + int'(wr_row) * COLS + int'(wr_column);
          mm[a] = wr_data; known[a] = 1;
        end
        if (swap_req && frame_complete && !m_ack) begin m_front = !m_front; ack_n = 1; end
        else if (swap_req) mode = 1;
        else if (clear_req) begin mode = 2; m_cidx = 0; m_cval = clear_val(); end
      end
      1: if (frame_complete) begin m_front = !m_front; ack_n = 1; mode = 0; end
      default: begin
        mm[back + m_cidx] = m_cval; known[back + m_cidx] = 1;
        if (swap_req) m_pend = 1;
        m_cidx++;
        if (m_cidx == N) begin mode = m_pend ? 1 : 0; m_pend = 0; end
      end
    endcase
    m_ack = ack_n;
    m_ready = (mode == 0);
  endtask

  task automatic check_outputs();
    chk("front_bank", front_bank, m_front);
    chk("swap_ack", swap_ack, m_ack);
    chk("clear_busy", clear_busy, mode == 2);
    chk("wr_ready", wr_ready, m_ready);
    chk("ack_twice", prev_ack & swap_ack, 0);
    if (m_pix_known) chk("disp_pixel", disp_pixel, m_pix);
    prev_ack = swap_ack;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic quiet();
    wr_valid = 0; swap_req = 0; frame_complete = 0; clear_req = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    model_reset();
    chk("rst_busy", clear_busy, 0);
    chk("rst_front", front_bank, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixel", disp_pixel, 24'h000000);
    chk("rst_ack", swap_ack, 0);
    chk("rst_ready", wr_ready, 0);
    rst = 1;
  endtask

  bit            saw_ack;
  int            cnt;
  logic          f0;
  logic [PW-1:0] clr_exp;

  initial begin
    clr_exp = clear_val();
    quiet();
    do_reset();
    step();
    chk("ready_after_rst", wr_ready, 1);

    // Host write lands in the back bank only
    wr_valid = 1; wr_row = 3; wr_column = 5; wr_data = 24'hff0000;
    disp_row = 3; disp_column = 5;
    step();
    wr_valid = 0;
    step();
    chk("front_untouched", disp_pixel == 24'hff0000, 0);

    // Swap request waits 10 cycles for frame_complete
    swap_req = 1; step(); swap_req = 0;
    for (int i = 0; i < 10; i++) begin step(); chk("ready_in_wait", wr_ready, 0); end
    frame_complete = 1; step(); frame_complete = 0;
    chk("swap_ack_pulse", swap_ack, 1);
    chk("front_after_swap", front_bank, 1);
    step();
    chk("swap_ack_drop", swap_ack, 0);
    chk("read_swapped", disp_pixel, 24'hff0000);

    // Simultaneous request and frame_complete
    swap_req = 1; frame_complete = 1; step(); quiet();
    chk("simul_front", front_bank, 0);
    chk("simul_ack", swap_ack, 1);
    chk("simul_ready", wr_ready, 1);
    step();

    // Full clear of bank 1, then display it
    clear_req = 1; step(); clear_req = 0;
    cnt = clear_busy ? 1 : 0;
    for (int i = 0; i < 300 && clear_busy; i++) begin
      step();
      if (clear_busy) begin cnt++; chk("ready_in_clear", wr_ready, 0); end
    end
    chk("clear_len", cnt, 256);
    swap_req = 1; frame_complete = 1; step(); quiet();
    for (int a = 0; a < N; a++) begin
      disp_row = 3'(a / COLS); disp_column = 5'(a % COLS);
      step();
      chk("cleared_pixel", disp_pixel, clr_exp);
    end

    // Swap requested mid-clear: only the post-clear frame_complete flips
    f0 = front_bank;
    saw_ack = 0;
    clear_req = 1; step(); clear_req = 0;
    for (int i = 0; i < N; i++) begin
      swap_req = (i == 100); frame_complete = (i == 150);
      step();
      saw_ack |= swap_ack;
    end
    quiet();
    chk("ack_during_clear", saw_ack, 0);
    chk("pending_wait_ready", wr_ready, 0);
    repeat (3) step();
    chk("front_held", front_bank, f0);
    frame_complete = 1; step(); frame_complete = 0;
    chk("pending_ack", swap_ack, 1);
    chk("pending_front", front_bank, !f0);
    step();

    // Reset in the middle of a clear
    clear_req = 1; step(); clear_req = 0;
    repeat (50) step();
    chk("busy_mid_clear", clear_busy, 1);
    #2;
    do_reset();
    step();
    chk("post_rst_ready", wr_ready, 1);
    chk("post_rst_front", front_bank, 0);
    chk("post_rst_busy", clear_busy, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_row = 3'($urandom); wr_column = 5'($urandom); wr_data = 24'($urandom);
      disp_row = 3'($urandom); disp_column = 5'($urandom);
      swap_req = ($urandom_range(0, 99) < 4);
      frame_complete = ($urandom_range(0, 99) < 12);
      clear_req = ($urandom_range(0, 99) < 2);
      clear_color = 24'($urandom);
      step();
    end
    quiet();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
